// File: rtl/lpc_host_cmd_seq.sv
// LPC host command sequencer: buffers byte requests, drives the host engine's ctrl_* controls,
// returns responses and owns host reset/timeout recovery. Define LPC_SEQ_RETRY_EN to retry failed cycles once.

`ifndef LPC_ST_IDLE
`define LPC_ST_IDLE 5'h00
`endif
`ifndef LPC_ST_FORCE_RESET
`define LPC_ST_FORCE_RESET 5'h1f
`endif

module lpc_host_cmd_seq #(
    parameter int FIFO_DEPTH     = 4,
    parameter int RESET_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic        req_mem_i,
    input  logic [15:0] req_addr_i,
    input  logic [7:0]  req_data_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_data_o,
    output logic        rsp_error_o,
    output logic        busy_o,
    output logic [15:0] ctrl_addr_o,
    output logic [7:0]  ctrl_data_o,
    output logic        ctrl_nrst_o,
    output logic        ctrl_lframe_o,
    output logic        ctrl_rd_status_o,
    output logic        ctrl_wr_status_o,
    output logic        ctrl_memory_cycle_o,
    input  logic [7:0]  ctrl_data_i,
    input  logic        ctrl_ready_i,
    input  logic [4:0]  ctrl_host_state_i
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
`ifdef LPC_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_RESET, S_WAIT_IDLE, S_IDLE, S_FRAME, S_WAIT_DONE, S_RESP, S_RECOVER
    } state_t;

    typedef struct packed {
        logic        write;
        logic        mem;
        logic [15:0] addr;
        logic [7:0]  data;
    } req_t;

    state_t           state_q, state_d;
    req_t             fifo_mem [FIFO_DEPTH];
    req_t             head;
    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic             push, pop, fifo_empty, full_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_last, timeout, abort, ready_prev_q, ready_rise;
    logic             cur_write_q, cur_write_d;
    logic             retry_pend_q, retry_pend_d, is_retry_q, is_retry_d;
    logic             nrst_d, lframe_d, rd_status_d, wr_status_d, mem_d;
    logic [15:0]      addr_d;
    logic [7:0]       data_d, rsp_data_d;
    logic             rsp_valid_d, rsp_error_d, ready_d, busy_d;

    assign push       = req_valid_i && req_ready_o;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign cnt_last   = (cnt_q == CNT_W'(RESET_CYCLES - 1));
    assign timeout    = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign abort      = (ctrl_host_state_i == `LPC_ST_FORCE_RESET) || timeout;
    assign ready_rise = ctrl_ready_i && !ready_prev_q;

    // NOTE: payload storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= '{write: req_write_i, mem: req_mem_i,
                                               addr: req_addr_i, data: req_data_i};
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RESET:     if (cnt_last) state_d = S_WAIT_IDLE;
            S_WAIT_IDLE: if (ctrl_host_state_i == `LPC_ST_IDLE) state_d = S_IDLE;
            S_IDLE:      if (retry_pend_q || !fifo_empty) state_d = S_FRAME;
            S_FRAME:     state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (ready_rise) begin
                    state_d = S_RESP;
                end else if (abort) begin
                    // A first-attempt failure with retry enabled recovers silently.
                    state_d = (RETRY_EN && !is_retry_q) ? S_RECOVER : S_RESP;
                end
            end
            S_RESP:      state_d = rsp_error_o ? S_RECOVER : S_WAIT_IDLE;
            S_RECOVER:   if (cnt_last) state_d = S_WAIT_IDLE;
            default:     state_d = S_RESET;
        endcase
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        pop          = 1'b0;
        cnt_d        = cnt_q;
        cur_write_d  = cur_write_q;
        retry_pend_d = retry_pend_q;
        is_retry_d   = is_retry_q;
        nrst_d       = ctrl_nrst_o;
        lframe_d     = 1'b1;
        rd_status_d  = ctrl_rd_status_o;
        wr_status_d  = ctrl_wr_status_o;
        mem_d        = ctrl_memory_cycle_o;
        addr_d       = ctrl_addr_o;
        data_d       = ctrl_data_o;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = rsp_data_o;
        rsp_error_d  = rsp_error_o;
        unique case (state_q)
            S_RESET, S_RECOVER: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_last) begin
                    nrst_d = 1'b1;
                    cnt_d  = '0;
                end
            end
            S_IDLE: begin
                if (retry_pend_q) begin
                    // Address, data and cycle type are still held from the failed attempt.
                    lframe_d     = 1'b0;
                    retry_pend_d = 1'b0;
                    is_retry_d   = 1'b1;
                end else if (!fifo_empty) begin
                    pop         = 1'b1;
                    addr_d      = head.addr;
                    data_d      = head.data;
                    mem_d       = head.mem;
                    cur_write_d = head.write;
                    lframe_d    = 1'b0;
                    is_retry_d  = 1'b0;
                end
            end
            S_FRAME: begin
                rd_status_d = !cur_write_q;
                wr_status_d = cur_write_q;
                cnt_d       = '0;
            end
            S_WAIT_DONE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (ready_rise) begin
                    rd_status_d = 1'b0;
                    wr_status_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = cur_write_q ? 8'h00 : ctrl_data_i;
                    rsp_error_d = 1'b0;
                end else if (abort) begin
                    rd_status_d = 1'b0;
                    wr_status_d = 1'b0;
                    if (RETRY_EN && !is_retry_q) begin
                        retry_pend_d = 1'b1;
                        nrst_d       = 1'b0;
                        cnt_d        = '0;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = 8'h00;
                        rsp_error_d = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (rsp_error_o) begin
                    nrst_d = 1'b0;
                    cnt_d  = '0;
                end
            end
            default: ;
        endcase
    end

    // Ready and busy are registered from next-cycle occupancy and state so they are exact.
    always_comb begin
        wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(push);
        rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(pop);
        full_d   = (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                   (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]);
        ready_d  = !full_d && !(state_d inside {S_RESET, S_RECOVER});
        busy_d   = (wr_ptr_d != rd_ptr_d) || !(state_d inside {S_IDLE, S_WAIT_IDLE}) ||
                   retry_pend_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            wr_ptr_q            <= '0;
            rd_ptr_q            <= '0;
            cnt_q               <= '0;
            ready_prev_q        <= 1'b0;
            cur_write_q         <= 1'b0;
            retry_pend_q        <= 1'b0;
            is_retry_q          <= 1'b0;
            req_ready_o         <= 1'b0;
            busy_o              <= 1'b0;
            rsp_valid_o         <= 1'b0;
            rsp_data_o          <= 8'h00;
            rsp_error_o         <= 1'b0;
            ctrl_nrst_o         <= 1'b0;
            ctrl_lframe_o       <= 1'b1;
            ctrl_rd_status_o    <= 1'b0;
            ctrl_wr_status_o    <= 1'b0;
            ctrl_memory_cycle_o <= 1'b0;
            ctrl_addr_o         <= 16'h0000;
            ctrl_data_o         <= 8'h00;
        end else begin
            wr_ptr_q            <= wr_ptr_d;
            rd_ptr_q            <= rd_ptr_d;
            cnt_q               <= cnt_d;
            ready_prev_q        <= ctrl_ready_i;
            cur_write_q         <= cur_write_d;
            retry_pend_q        <= retry_pend_d;
            is_retry_q          <= is_retry_d;
            req_ready_o         <= ready_d;
            busy_o              <= busy_d;
            rsp_valid_o         <= rsp_valid_d;
            rsp_data_o          <= rsp_data_d;
            rsp_error_o         <= rsp_error_d;
            ctrl_nrst_o         <= nrst_d;
            ctrl_lframe_o       <= lframe_d;
            ctrl_rd_status_o    <= rd_status_d;
            ctrl_wr_status_o    <= wr_status_d;
            ctrl_memory_cycle_o <= mem_d;
            ctrl_addr_o         <= addr_d;
            ctrl_data_o         <= data_d;
        end
    end

endmodule
